// File: rtl/mbt_scan_ctrl.sv
// rtl/mbt_scan_ctrl.sv - frame scan initiator for the Mandelbrot iteration ALU
// Walks the pixel grid, restarts the ALU per pixel and writes iteration counts to the frame buffer.
module mbt_scan_ctrl #(
    parameter int          H_RES    = 320,
    parameter int          V_RES    = 240,
    parameter int          ADDR_W   = 17,
    parameter logic [15:0] X_MIN    = 16'hF800,
    parameter logic [15:0] Y_MAX    = 16'h04B0,
    parameter logic [6:0]  MAX_ITER = 7'd99,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [1:0]        zoom,
    output logic              alu_rst,
    output logic              alu_start,
    output logic [15:0]       c_real,
    output logic [15:0]       c_img,
    input  logic              alu_valid,
    input  logic [6:0]        alu_iter,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [6:0]        fb_data,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARST   = 3'd1;
    localparam logic [2:0] S_ASTART = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  state;
    logic [15:0] step;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  wdog;
    logic        last_col;
    logic        last_row;

    assign last_col = (x == 16'(H_RES - 1));
    assign last_row = (y == 16'(V_RES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            step        <= '0;
            x           <= '0;
            y           <= '0;
            wdog        <= '0;
            alu_rst     <= 1'b0;
            alu_start   <= 1'b0;
            c_real      <= '0;
            c_img       <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            alu_rst    <= 1'b0;
            alu_start  <= 1'b0;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        step        <= 16'h0008 >> zoom;
                        x           <= '0;
                        y           <= '0;
                        fb_addr     <= '0;
                        c_real      <= X_MIN;
                        c_img       <= Y_MAX;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        alu_rst     <= 1'b1;
                        state       <= S_ARST;
                    end
                end
                S_ARST: begin
                    alu_start <= 1'b1;
                    state     <= S_ASTART;
                end
                S_ASTART: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A valid arriving on the expiry cycle still wins over the watchdog.
                    if (alu_valid) begin
                        fb_data <= alu_iter;
                        fb_we   <= 1'b1;
                        state   <= S_WRITE;
                    end else if (wdog == TIMEOUT) begin
                        fb_data     <= MAX_ITER;
                        timeout_err <= 1'b1;
                        fb_we       <= 1'b1;
                        state       <= S_WRITE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                S_WRITE: begin
                    if (last_col && last_row) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        if (last_col) begin
                            x      <= '0;
                            y      <= y + 16'd1;
                            c_real <= X_MIN;
                            c_img  <= c_img - step;
                        end else begin
                            x      <= x + 16'd1;
                            c_real <= c_real + step;
                        end
                        fb_addr <= fb_addr + ADDR_W'(1);
                        alu_rst <= 1'b1;
                        state   <= S_ARST;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
